// File: rtl/tile_blit_if.sv
// Lookup-path and pixel-sink signals between the tile blitter and its neighbours.
// o_read is a one-cycle request for the texel at (o_tile_x,o_tile_y); the coordinate holds until i_valid
// answers (same cycle or later) or the request times out. o_pix_we is a one-cycle write with no backpressure.
interface tile_blit_if #(
  parameter int COORD_W = 10
) ();
  logic [3:0]         o_tile_no;
  logic [1:0]         o_tile_x;
  logic [1:0]         o_tile_y;
  logic [1:0]         o_mirror;
  logic [1:0]         o_rotate;
  logic               o_read;
  logic [23:0]        i_rgb_data;
  logic               i_valid;
  logic               o_pix_we;
  logic [COORD_W-1:0] o_pix_x;
  logic [COORD_W-1:0] o_pix_y;
  logic [23:0]        o_pix_rgb;

  modport master (
    output o_tile_no, o_tile_x, o_tile_y, o_mirror, o_rotate, o_read,
    output o_pix_we, o_pix_x, o_pix_y, o_pix_rgb,
    input  i_rgb_data, i_valid
  );

  modport slave (
    input  o_tile_no, o_tile_x, o_tile_y, o_mirror, o_rotate, o_read,
    input  o_pix_we, o_pix_x, o_pix_y, o_pix_rgb,
    output i_rgb_data, i_valid
  );
endinterface

// File: rtl/tile_blit_ctrl.sv
// Draws one 4x4 tile: walks the 16 tile coordinates in raster order, reads each texel
// from the lookup path and writes it to the pixel sink, with colour-key, timeout and abort.
module tile_blit_ctrl #(
  parameter int          COORD_W         = 10,
  parameter int          TIMEOUT         = 15,
  parameter logic [23:0] TRANSPARENT_KEY = 24'hFF00FF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [3:0]         i_tile_no,
  input  logic [1:0]         i_mirror,
  input  logic [1:0]         i_rotate,
  input  logic [COORD_W-1:0] i_base_x,
  input  logic [COORD_W-1:0] i_base_y,
  input  logic               i_transparent_en,
  tile_blit_if.master        io_blit,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_tile_no;
  logic [1:0]         r_mirror;
  logic [1:0]         r_rotate;
  logic [COORD_W-1:0] r_base_x;
  logic [COORD_W-1:0] r_base_y;
  logic               r_trans_en;
  logic [1:0]         r_x;
  logic [1:0]         r_y;
  logic [7:0]         r_cnt;
  logic               r_err;
  logic               r_pix_we;
  logic [COORD_W-1:0] r_pix_x;
  logic [COORD_W-1:0] r_pix_y;
  logic [23:0]        r_pix_rgb;

  logic w_start;
  logic w_capture;
  logic w_skip;
  logic w_advance;
  logic w_last;
  logic w_read;
  logic w_done;

  assign w_last    = (r_x == 2'd3) && (r_y == 2'd3);
  assign w_advance = w_capture | w_skip;

  // Abort outranks valid and timeout; valid outranks timeout.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_skip    = 1'b0;
    w_read    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_start = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_read = 1'b1;
        if (i_abort)              w_next = S_IDLE;
        else if (io_blit.i_valid) w_capture = 1'b1;
        else                      w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_abort)                   w_next = S_IDLE;
        else if (io_blit.i_valid)      w_capture = 1'b1;
        else if (r_cnt == TIMEOUT_M1)  w_skip = 1'b1;
      end
      S_DONE: begin
        w_done = !i_abort;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_capture || w_skip) w_next = w_last ? S_DONE : S_ISSUE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_tile_no  <= '0;
      r_mirror   <= '0;
      r_rotate   <= '0;
      r_base_x   <= '0;
      r_base_y   <= '0;
      r_trans_en <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_pix_we   <= 1'b0;
      r_pix_x    <= '0;
      r_pix_y    <= '0;
      r_pix_rgb  <= '0;
    end else begin
      r_state  <= w_next;
      r_pix_we <= 1'b0;
      if (w_start) begin
        r_tile_no  <= i_tile_no;
        r_mirror   <= i_mirror;
        r_rotate   <= i_rotate;
        r_base_x   <= i_base_x;
        r_base_y   <= i_base_y;
        r_trans_en <= i_transparent_en;
        r_x        <= '0;
        r_y        <= '0;
        r_err      <= 1'b0;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
      // Coordinates and data update even for a keyed-out pixel; only the strobe is held off.
      if (w_capture) begin
        r_pix_we  <= !(r_trans_en && (io_blit.i_rgb_data == TRANSPARENT_KEY));
        r_pix_x   <= r_base_x + COORD_W'(r_x);
        r_pix_y   <= r_base_y + COORD_W'(r_y);
        r_pix_rgb <= io_blit.i_rgb_data;
      end
      if (w_advance) begin
        r_x <= r_x + 2'd1;
        if (r_x == 2'd3) r_y <= r_y + 2'd1;
      end
      if (w_skip) r_err <= 1'b1;
    end
  end

  assign io_blit.o_tile_no = r_tile_no;
  assign io_blit.o_tile_x  = r_x;
  assign io_blit.o_tile_y  = r_y;
  assign io_blit.o_mirror  = r_mirror;
  assign io_blit.o_rotate  = r_rotate;
  assign io_blit.o_read    = w_read;
  assign io_blit.o_pix_we  = r_pix_we;
  assign io_blit.o_pix_x   = r_pix_x;
  assign io_blit.o_pix_y   = r_pix_y;
  assign io_blit.o_pix_rgb = r_pix_rgb;
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = w_done;
  assign o_err             = r_err;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_tile_blit_ctrl.sv
// Directed bench for tile_blit_ctrl: a latency-configurable texel source, and a scoreboard of
// expected {cycle, x, y, rgb} writes pushed per tile and popped on every o_pix_we.
module tb_tile_blit_ctrl;
  localparam int          CW  = 10;
  localparam int          TMO = 15;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam int          QW  = 8 + 2 * CW + 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, ten;
  logic [3:0]    tno;
  logic [1:0]    mir, rot;
  logic [CW-1:0] bx, by;
  logic          busy, done, err;
  logic [1:0]    dbg;

  tile_blit_if #(.COORD_W(CW)) bus ();

  tile_blit_ctrl #(.COORD_W(CW), .TIMEOUT(TMO), .TRANSPARENT_KEY(KEY)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_tile_no(tno), .i_mirror(mir), .i_rotate(rot),
    .i_base_x(bx), .i_base_y(by), .i_transparent_en(ten),
    .io_blit(bus),
    .o_busy(busy), .o_done(done), .o_err(err), .o_dbg_state(dbg)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  logic [QW-1:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Texel source: data keyed by coordinate, answered src_lat cycles after the read.
  logic [23:0] src_data [16];
  int          src_lat   = 0;
  bit          src_drop0 = 1'b0;
  logic        pend      = 1'b0;
  int          pend_cnt  = 0;
  logic [3:0]  coord;

  assign coord          = {bus.o_tile_y, bus.o_tile_x};
  assign bus.i_rgb_data = src_data[coord];
  assign bus.i_valid    = !(src_drop0 && coord == 4'd0) &&
                          ((src_lat == 0) ? bus.o_read : (pend && pend_cnt == 0));

  always @(posedge clk) begin
    if (bus.o_read && src_lat > 0) begin
      pend     <= 1'b1;
      pend_cnt <= src_lat - 1;
    end else if (pend) begin
      if (pend_cnt == 0) pend <= 1'b0;
      else               pend_cnt <= pend_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: counts reads/writes/done and checks every write against the scoreboard.
  int   wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_rel = -1;
  logic done_err = 1'b0;
  logic [QW-1:0] m_obs, m_exp;

  always @(negedge clk) begin
    if (bus.o_read) rd_cnt++;
    if (done) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
      done_err = err;
    end
    if (bus.o_pix_we) begin
      wr_cnt++;
      m_obs = {8'(cyc - start_cyc), bus.o_pix_x, bus.o_pix_y, bus.o_pix_rgb};
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%0h expected=none", m_obs);
      end
      if (exp_q.size() != 0) begin
        m_exp = exp_q.pop_front();
        check("pix_write", 64'(m_obs), 64'(m_exp));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wr_rel(input int k, input int lat, input bit drop0);
    int issue;
    issue = 1 + k * (lat + 1) + ((drop0 && k > 0) ? TMO : 0);
    return 8'(issue + lat + 1);
  endfunction

  task automatic push_tile(input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                           input int lat, input bit drop0, input bit te, input int last_k);
    for (int k = 0; k <= last_k; k++) begin
      if (drop0 && k == 0) continue;
      if (te && src_data[k] == KEY) continue;
      exp_q.push_back({wr_rel(k, lat, drop0), CW'(x0 + k % 4), CW'(y0 + k / 4), src_data[k]});
    end
  endtask

  task automatic start_tile(input logic [3:0] t, input logic [1:0] m, input logic [1:0] r,
                            input logic [CW-1:0] x, input logic [CW-1:0] y, input logic te);
    tno = t; mir = m; rot = r; bx = x; by = y; ten = te;
    start = 1'b1;
    start_cyc = cyc;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_rel = -1; done_err = 1'b0;
    tick(1);
    start = 1'b0;
    tno = 4'($urandom); mir = 2'($urandom); rot = 2'($urandom);
    bx = CW'($urandom); by = CW'($urandom); ten = 1'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check("busy_timeout", 64'(busy), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ten = 1'b0;
    tno = '0; mir = '0; rot = '0; bx = '0; by = '0;
    for (int i = 0; i < 16; i++) src_data[i] = 24'(i);
    tick(3);
    rst = 1'b0;

    // Reset state
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    check("reset_state", 64'(dbg), 64'(0));
    check("reset_read_we", 64'({bus.o_read, bus.o_pix_we}), 64'(0));
    check("reset_latched", 64'({bus.o_tile_no, bus.o_mirror, bus.o_rotate, bus.o_tile_x, bus.o_tile_y}), 64'(0));
    check("reset_pix", 64'({bus.o_pix_x, bus.o_pix_y, bus.o_pix_rgb}), 64'(0));

    // Start together with abort does not start
    tno = 4'd5; start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'(0));
    check("start_abort_tile", 64'(bus.o_tile_no), 64'(0));

    // Zero-latency ramp
    src_lat = 0;
    push_tile(10'd100, 10'd50, 0, 1'b0, 1'b0, 15);
    start_tile(4'd3, 2'd0, 2'd0, 10'd100, 10'd50, 1'b0);
    check("t1_busy_c1", 64'(busy), 64'(1));
    wait_idle(100);
    check("t1_busy_fall", 64'(cyc - start_cyc), 64'(18));
    check("t1_done_cnt", 64'(done_cnt), 64'(1));
    check("t1_done_rel", 64'(done_rel), 64'(17));
    check("t1_reads", 64'(rd_cnt), 64'(16));
    check("t1_writes", 64'(wr_cnt), 64'(16));
    check("t1_queue", 64'(exp_q.size()), 64'(0));
    check("t1_tile_no", 64'(bus.o_tile_no), 64'(3));

    // Latency-2 source
    src_lat = 2;
    push_tile(10'd100, 10'd50, 2, 1'b0, 1'b0, 15);
    start_tile(4'd3, 2'd0, 2'd0, 10'd100, 10'd50, 1'b0);
    wait_idle(200);
    check("t2_done_rel", 64'(done_rel), 64'(49));
    check("t2_reads", 64'(rd_cnt), 64'(16));
    check("t2_writes", 64'(wr_cnt), 64'(16));
    check("t2_err", 64'(err), 64'(0));
    check("t2_queue", 64'(exp_q.size()), 64'(0));

    // Transparency with key at pixels 5 and 10
    src_lat = 0;
    for (int i = 0; i < 16; i++) src_data[i] = 24'($urandom) & 24'h7FFFFF;
    src_data[5] = KEY; src_data[10] = KEY;
    push_tile(10'd200, 10'd300, 0, 1'b0, 1'b1, 15);
    start_tile(4'd9, 2'd1, 2'd2, 10'd200, 10'd300, 1'b1);
    wait_idle(100);
    check("t3_writes", 64'(wr_cnt), 64'(14));
    check("t3_done_rel", 64'(done_rel), 64'(17));
    check("t3_queue", 64'(exp_q.size()), 64'(0));
    check("t3_mir_rot", 64'({bus.o_mirror, bus.o_rotate}), 64'({2'd1, 2'd2}));

    // Timeout on pixel 0; key value written because transparency is off
    src_data[7] = KEY;
    src_drop0 = 1'b1;
    push_tile(10'd0, 10'd0, 0, 1'b1, 1'b0, 15);
    start_tile(4'd6, 2'd3, 2'd1, 10'd0, 10'd0, 1'b0);
    wait_idle(100);
    src_drop0 = 1'b0;
    check("t4_writes", 64'(wr_cnt), 64'(15));
    check("t4_reads", 64'(rd_cnt), 64'(16));
    check("t4_done_rel", 64'(done_rel), 64'(32));
    check("t4_err_at_done", 64'(done_err), 64'(1));
    check("t4_err_held", 64'(err), 64'(1));
    check("t4_queue", 64'(exp_q.size()), 64'(0));

    // Abort after the 7th write, with a start request while busy
    for (int i = 0; i < 16; i++) src_data[i] = 24'h100 + 24'(i);
    push_tile(10'd5, 10'd7, 0, 1'b0, 1'b0, 6);
    start_tile(4'd12, 2'd2, 2'd3, 10'd5, 10'd7, 1'b0);
    check("t5_err_cleared", 64'(err), 64'(0));
    tick(3);
    tno = 4'd15; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_idle_after_abort", 64'({busy, dbg}), 64'(0));
    tick(5);
    check("t5_writes", 64'(wr_cnt), 64'(7));
    check("t5_reads", 64'(rd_cnt), 64'(8));
    check("t5_no_done", 64'(done_cnt), 64'(0));
    check("t5_queue", 64'(exp_q.size()), 64'(0));
    check("t5_tile_kept", 64'(bus.o_tile_no), 64'(12));

    // Reset mid-tile
    push_tile(10'd40, 10'd41, 0, 1'b0, 1'b0, 3);
    start_tile(4'd7, 2'd1, 2'd1, 10'd40, 10'd41, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_latched_cleared", 64'({bus.o_tile_no, bus.o_mirror, bus.o_pix_x}), 64'(0));
    tick(5);
    check("t6_writes", 64'(wr_cnt), 64'(4));
    check("t6_no_done", 64'(done_cnt), 64'(0));
    check("t6_queue", 64'(exp_q.size()), 64'(0));

    // Coordinate wrap with latency-1 source
    src_lat = 1;
    for (int i = 0; i < 16; i++) src_data[i] = 24'($urandom);
    push_tile(10'd1022, 10'd1023, 1, 1'b0, 1'b0, 15);
    start_tile(4'd1, 2'd0, 2'd0, 10'd1022, 10'd1023, 1'b0);
    wait_idle(100);
    check("t7_writes", 64'(wr_cnt), 64'(16));
    check("t7_done_rel", 64'(done_rel), 64'(33));
    check("t7_queue", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
